// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-like inst/data ports onto single-beat AXI transactions, one at a time.
// Optional response checking (rresp/bresp ports, sticky bus_err) is enabled by defining BRIDGE_RESP_CHECK_EN.
module sram_axi_bridge #(
   parameter bit DATA_FIRST = 1'b1,
   parameter bit ADDR_MAP   = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_en,
   input  logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stall_by_sram,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
`ifdef BRIDGE_RESP_CHECK_EN
  ,input  logic [1:0]  rresp,
   input  logic [1:0]  bresp,
   output logic        bus_err
`endif
);

   typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW, WR_B, SEL, DONE} state_t;

   state_t      state, state_next;
   logic        inst_done, data_done;
   logic        serve_data, serve_wr;
   logic        aw_pend, w_pend;
   logic [31:0] addr_q, wdata_q, rbuf;
   logic [3:0]  wstrb_q;

   logic inst_pend, data_pend, pick_data, pick_wr, other_pend, aw_ok, w_ok;

   // kseg0/kseg1 both alias the low 512 MB of physical space.
   function automatic logic [31:0] map_addr(input logic [31:0] a);
      if (ADDR_MAP && a[31:30] == 2'b10) map_addr = {3'b000, a[28:0]};
      else                               map_addr = a;
   endfunction

   assign inst_pend     = inst_sram_en & ~inst_done;
   assign data_pend     = data_sram_en & ~data_done;
   assign stall_by_sram = inst_pend | data_pend;
   assign pick_data     = data_pend & (DATA_FIRST | ~inst_pend);
   assign pick_wr       = pick_data & (|data_sram_wen);
   assign other_pend    = serve_data ? inst_pend : data_pend;
   assign aw_ok         = ~aw_pend | awready;
   assign w_ok          = ~w_pend | wready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_next;
      end
   end

   // NOTE: every always_comb output gets a default first, otherwise an uncovered path infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (stall_by_sram) state_next = pick_wr ? WR_AW : RD_AR;
         RD_AR: if (arready) state_next = RD_R;
         RD_R:  if (rvalid) state_next = SEL;
         WR_AW: if (aw_ok && w_ok) state_next = WR_B;
         WR_B:  if (bvalid) state_next = SEL;
         SEL:   state_next = other_pend ? IDLE : DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      arvalid = 1'b0;
      rready  = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      case (state)
         RD_AR: arvalid = 1'b1;
         RD_R:  rready  = 1'b1;
         WR_AW: begin
            awvalid = aw_pend;
            wvalid  = w_pend;
         end
         WR_B:  bready  = 1'b1;
         default: ;
      endcase
   end

   assign araddr = addr_q;
   assign awaddr = addr_q;
   assign wdata  = wdata_q;
   assign wstrb  = wstrb_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inst_done       <= 1'b0;
         data_done       <= 1'b0;
         serve_data      <= 1'b0;
         serve_wr        <= 1'b0;
         aw_pend         <= 1'b0;
         w_pend          <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         wstrb_q         <= '0;
         rbuf            <= '0;
         inst_sram_rdata <= '0;
         data_sram_rdata <= '0;
      end else begin
         case (state)
            IDLE: if (stall_by_sram) begin
               serve_data <= pick_data;
               serve_wr   <= pick_wr;
               addr_q     <= map_addr(pick_data ? data_sram_addr : inst_sram_addr);
               wdata_q    <= data_sram_wdata;
               wstrb_q    <= pick_wr ? data_sram_wen : 4'b0000;
               aw_pend    <= pick_wr;
               w_pend     <= pick_wr;
            end
            WR_AW: begin
               // AW and W complete independently; each valid drops on its own handshake.
               if (awready) aw_pend <= 1'b0;
               if (wready)  w_pend  <= 1'b0;
            end
            RD_R: if (rvalid) rbuf <= rdata;
            SEL: begin
               // Read data becomes visible to the core from the following cycle on.
               if (serve_data) begin
                  data_done <= 1'b1;
                  if (!serve_wr) data_sram_rdata <= rbuf;
               end else begin
                  inst_done       <= 1'b1;
                  inst_sram_rdata <= rbuf;
               end
            end
            DONE: begin
               inst_done <= 1'b0;
               data_done <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef BRIDGE_RESP_CHECK_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus_err <= 1'b0;
      end else if ((rvalid && rready && rresp != 2'b00) || (bvalid && bready && bresp != 2'b00)) begin
         bus_err <= 1'b1;
      end
   end
`endif

endmodule
